// File: rtl/seq_mul_unit_if.sv
// Request/result handshake bundle between issue logic and the sequential multiplier.
// The master side belongs to issue/consume logic. The slave side belongs to seq_mul_unit.
interface seq_mul_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [1:0]      op_sel;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, op_a, op_b, op_sel, res_ready,
    input  req_ready, res_valid, result, busy
  );

  modport slave (
    input  req_valid, op_a, op_b, op_sel, res_ready,
    output req_ready, res_valid, result, busy
  );
endinterface

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU using sign-magnitude operands.
// Optional macro SEQ_MUL_EARLY_EXIT_EN ends CALC as soon as the remaining multiplier is zero.
module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  seq_mul_unit_if.slave   bus
);
  localparam int W2 = 2 * XLEN;
  localparam int NT = W2 / 4;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   count_q, count_d;
  logic            req_ready_q, req_ready_d;
  logic            res_valid_q, res_valid_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [W2-1:0]   add_sum;
  logic [CW-1:0]   next_count;
  logic [XLEN-1:0] next_mplier;
  logic            last_iter;

  // Ripple-carry adder of acc + mcand, tiled in 4-bit groups; the final carry-out is dropped.
  logic [NT-1:0] tile_cin;
  assign tile_cin[0] = 1'b0;

  for (genvar g = 0; g < NT; g++) begin : g_tile
    logic [3:0] c;
    assign c[0] = tile_cin[g];
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign add_sum[4*g+b] = acc_q[4*g+b] ^ mcand_q[4*g+b] ^ c[b];
      if (b < 3) begin : g_c
        assign c[b+1] = (acc_q[4*g+b] & mcand_q[4*g+b]) | (c[b] & (acc_q[4*g+b] ^ mcand_q[4*g+b]));
      end
    end
    if (g < NT - 1) begin : g_co
      assign tile_cin[g+1] = (acc_q[4*g+3] & mcand_q[4*g+3]) | (c[3] & (acc_q[4*g+3] ^ mcand_q[4*g+3]));
    end
  end

  always_comb begin
    sign_a      = bus.op_a[XLEN-1] && (bus.op_sel != 2'b11);
    sign_b      = bus.op_b[XLEN-1] && !bus.op_sel[1];
    mag_a       = sign_a ? (~bus.op_a + XLEN'(1)) : bus.op_a;
    mag_b       = sign_b ? (~bus.op_b + XLEN'(1)) : bus.op_b;
    next_count  = count_q + CW'(1);
    next_mplier = mplier_q >> 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    last_iter   = (next_count == CW'(XLEN)) || (next_mplier == '0);
`else
    last_iter   = (next_count == CW'(XLEN));
`endif
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d     = bus.op_sel;
          neg_d    = sign_a ^ sign_b;
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (mplier_q[0]) acc_d = add_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = next_mplier;
        count_d  = next_count;
        if (last_iter) state_d = FIXUP;
      end
      FIXUP: begin
        if (neg_q) acc_d = ~acc_q + W2'(1);
        state_d = DONE;
      end
      DONE: begin
        // The result word is captured once so it stays stable under backpressure.
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          result_d    = (op_q == 2'b00) ? acc_q[XLEN-1:0] : acc_q[W2-1:XLEN];
        end else if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
// Scoreboard bench for seq_mul_unit: expected words and latencies come from a native-multiply model.
// Build with SEQ_MUL_EARLY_EXIT_EN defined to check the early-exit latencies.
module tb_seq_mul_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_mul_unit_if #(.XLEN(XLEN)) bus();

  seq_mul_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic               ea, eb;
    logic signed [65:0] pa, pb, prod;
    logic [31:0]        mb;
    int                 it;
    exp_t               e;
    ea   = (op != 2'b11) & a[31];
    eb   = !op[1] & b[31];
    pa   = $signed({{34{ea}}, a});
    pb   = $signed({{34{eb}}, b});
    prod = pa * pb;
    e.res = (op == 2'b00) ? prod[31:0] : prod[63:32];
    mb = eb ? (32'd0 - b) : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (mb[i]) it = i + 1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    e.lat = it + 2;
`else
    e.lat = XLEN + 2;
`endif
    return e;
  endfunction

  // Waits for req_ready, presents one request, then scrambles the inputs after the accept edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("req_ready_before_accept", bus.req_ready, 1);
    bus.op_sel    = op;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.op_a      = ~a;
    bus.op_b      = a ^ b;
    bus.op_sel    = ~op;
    sb_q.push_back(modelOp(op, a, b));
    checkOutput("busy_after_accept", bus.busy, 1);
  endtask

  // Called right after applyStimulus; optionally holds res_ready low while poking req_valid.
  task automatic collectResult(input string tag, input int hold_cycles);
    int   cycles = 0;
    exp_t e;
    while (!bus.res_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(e.lat));
    checkOutput({tag, "_result"}, bus.result, e.res);
    if (hold_cycles > 0) begin
      bus.req_valid = 1'b1;
      bus.op_a      = 32'd5;
      bus.op_b      = 32'd5;
      bus.op_sel    = 2'b00;
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_valid"}, bus.res_valid, 1);
      checkOutput({tag, "_hold_result"}, bus.result, e.res);
      checkOutput({tag, "_hold_req_ready"}, bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, bus.res_valid, 0);
    checkOutput({tag, "_idle_ready"}, bus.req_ready, 1);
  endtask

  logic [1:0]  d_op [12];
  logic [31:0] d_a  [12];
  logic [31:0] d_b  [12];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    d_op = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
    d_a  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000,
             32'd3, 32'd9, 32'h1234_5678, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9};
    d_b  = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
             32'd1, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001, 32'd6};

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.op_sel    = 2'b00;
    bus.res_ready = 1'b0;
    #2;
    checkOutput("reset_req_ready", bus.req_ready, 1);
    checkOutput("reset_res_valid", bus.res_valid, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_result", bus.result, 0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(d_op[i], d_a[i], d_b[i]);
      collectResult($sformatf("dir%0d", i), 0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom);
      collectResult($sformatf("rnd%0d", i), 0);
    end

    // Backpressure with ignored requests, then a back-to-back request on the first IDLE cycle.
    applyStimulus(2'b00, 32'h0000_1234, 32'h0000_5678);
    collectResult("bp", 10);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'd2);
    collectResult("b2b", 0);

    // Reset partway through CALC drops the operation.
    applyStimulus(2'b11, 32'h0001_0000, 32'h0001_0000);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_req_ready", bus.req_ready, 1);
    checkOutput("midreset_res_valid", bus.res_valid, 0);
    checkOutput("midreset_busy", bus.busy, 0);
    checkOutput("midreset_result", bus.result, 0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("after_reset_no_valid", bus.res_valid, 0);
    applyStimulus(2'b11, 32'h0001_0000, 32'h0001_0000);
    collectResult("post_reset", 0);

    checkOutput("scoreboard_drained", 64'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Iterative shift-add multiplier implementing the RV32M MUL/MULH/MULHSU/MULHU operations.
- Sits in the execute stage beside the ALU and is driven by the decode/issue logic.
- Each cycle it presents the 2*XLEN running accumulator and the shifted multiplicand to a ripple-carry adder chain built from the lib full-adder cells. It registers the sum back into the accumulator.
- Valid/ready handshakes on both the request side and the result side.

Parameters:
- XLEN, 32, operand and result width; must be a multiple of 4 so the adder chain tiles in 4-bit adder cells.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- op_a  in  XLEN  multiplicand (rs1)
- op_b  in  XLEN  multiplier (rs2)
- op_sel  in  2  00=MUL (low word), 01=MULH (s*s high), 10=MULHSU (s*u high), 11=MULHU (u*u high)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  XLEN  selected product word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Applies immediately, asynchronous; one clock of clk is enough to complete it.
  - State=IDLE; req_ready=1, res_valid=0, busy=0, result=0; all internal registers cleared.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge:
    - latch op_sel.
    - sign_a = op_a[XLEN-1] for MUL/MULH/MULHSU, else 0.
    - sign_b = op_b[XLEN-1] for MUL/MULH, else 0.
    - mcand (2*XLEN) = zero-extended |op_a|; mplier (XLEN) = |op_b|.
    - negate flag = sign_a^sign_b; acc=0; count=0; go to CALC.
  - For MUL, the low word is sign-independent; it still uses the signed path.
- CALC, one iteration per cycle:
  - if mplier[0], acc <= acc + mcand (2*XLEN adder; carry-out discarded).
  - mcand <<= 1; mplier >>= 1; count++.
  - Go to FIXUP after the edge where count reaches XLEN.
- FIXUP, one cycle:
  - if the negate flag is set, acc <= ~acc + 1 (2*XLEN two's complement).
  - Go to DONE.
- DONE:
  - res_valid=1; result = acc[XLEN-1:0] for MUL, else acc[2*XLEN-1:XLEN].
  - result is held stable while res_valid && !res_ready.
  - On res_valid&&res_ready: go to IDLE, res_valid drops next cycle.
- req_ready=0 in every state except IDLE. No request overlap; a new request is accepted no earlier than the cycle after the result handshake.
- Latency (feature off): res_valid first high XLEN+2 cycles after the accept edge (XLEN CALC cycles + 1 FIXUP + register).
- Boundaries:
  - |0x80000000| = 0x80000000 as an unsigned magnitude; no overflow trap.
  - Zero operands take the full latency.
  - req_valid asserted while busy is ignored (not queued).
  - An asynchronous reset mid-CALC or in DONE aborts the operation; the result is lost and no res_valid is produced.
- op_a/op_b/op_sel may change after the accept edge without effect.

Optional Feature:
- Macro: SEQ_MUL_EARLY_EXIT_EN.
- Defined:
  - In CALC, the block also goes to FIXUP after any edge where the shifted mplier becomes 0.
  - Iterations = max(1, index of highest set bit of |op_b| + 1).
  - Results are identical to the feature-off case, because the accumulate-on-left-shift form needs no realignment.
- Undefined: always XLEN iterations, fixed latency.

Test Plan:
- MUL op_a=7, op_b=6 -> result=0x0000002A; res_valid exactly 34 cycles after accept (feature off, XLEN=32).
- MULH op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0x00000000. MUL with the same operands -> 0x00000001.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU op_a=0xFFFFFFFE (-2), op_b=0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000*0x80000000 -> 0x40000000.
- Backpressure: hold res_ready=0 for 10 cycles in DONE -> res_valid and result stable, req_ready=0. Then pulse res_ready -> IDLE next cycle; a back-to-back request is accepted the following cycle.
- Assert reset mid-CALC (cycle 10) -> outputs return to reset values immediately. A new request afterwards computes correctly (MULHU 0x10000*0x10000 -> 0x00000001).
- With SEQ_MUL_EARLY_EXIT_EN:
  - MUL 3*1 -> result=3, res_valid 3 cycles after accept.
  - op_b=0 -> result=0, res_valid 3 cycles after accept.
  - op_b=0x80000000 with MULHU -> full 34-cycle latency.
